// File: rtl/request_compactor.sv
// Round-robin request compactor: packs up to NUM_LANES valid requests from NUM_PORTS ports
// into the lowest output lanes, tagged with the source port ID, with one register stage.
module request_compactor #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned TAG_W     = 2,
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned ID_W      = $clog2(NUM_PORTS + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_PORTS*WIDTH-1:0]   port_data_in,
    input  logic [NUM_PORTS*TAG_W-1:0]   port_tag_in,
    input  logic [NUM_PORTS-1:0]         port_valid_in,
    output logic [NUM_PORTS-1:0]         port_ready_out,
    output logic [NUM_LANES*WIDTH-1:0]   lane_data_out,
    output logic [NUM_LANES*TAG_W-1:0]   lane_tag_out,
    output logic [NUM_LANES*ID_W-1:0]    lane_id_out,
    output logic [NUM_LANES-1:0]         lane_valid_out,
    input  logic                         out_ready_in
);

    localparam int unsigned PTR_W = $clog2(NUM_PORTS);

    logic [PTR_W-1:0]           ptr_q;
    logic                       grp_v;
    logic                       load;
    logic [NUM_PORTS-1:0]       granted;
    logic [PTR_W-1:0]           lane_sel [NUM_LANES];
    logic [NUM_LANES-1:0]       lane_hit;
    logic [PTR_W-1:0]           last_idx;
    logic                       any_grant;
    int unsigned                n_grant;
    int unsigned                scan_idx;

    logic [NUM_LANES*WIDTH-1:0] lane_data_d;
    logic [NUM_LANES*TAG_W-1:0] lane_tag_d;
    logic [NUM_LANES*ID_W-1:0]  lane_id_d;
    logic [NUM_LANES-1:0]       lane_valid_d;

    assign grp_v          = |lane_valid_out;
    assign load           = !grp_v | out_ready_in;
    assign port_ready_out = granted & {NUM_PORTS{load & rst_n}};

    // Walk ports in rotated order from ptr; the n-th valid port found feeds lane n.
    always_comb begin
        granted   = '0;
        lane_hit  = '0;
        last_idx  = '0;
        any_grant = 1'b0;
        n_grant   = 0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            lane_sel[k] = '0;
        end
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            scan_idx = 32'(ptr_q) + j;
            if (scan_idx >= NUM_PORTS) begin
                scan_idx = scan_idx - NUM_PORTS;
            end
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (i == scan_idx && port_valid_in[i] && n_grant < NUM_LANES) begin
                    granted[i] = 1'b1;
                    for (int unsigned k = 0; k < NUM_LANES; k++) begin
                        if (k == n_grant) begin
                            lane_sel[k] = PTR_W'(i);
                            lane_hit[k] = 1'b1;
                        end
                    end
                    last_idx  = PTR_W'(i);
                    any_grant = 1'b1;
                    n_grant   = n_grant + 1;
                end
            end
        end
    end

    always_comb begin
        lane_data_d  = '0;
        lane_tag_d   = '0;
        lane_id_d    = '0;
        lane_valid_d = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            if (lane_hit[k]) begin
                lane_valid_d[k] = 1'b1;
                for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                    if (lane_sel[k] == PTR_W'(i)) begin
                        lane_data_d[k*WIDTH +: WIDTH] = port_data_in[i*WIDTH +: WIDTH];
                        lane_tag_d[k*TAG_W +: TAG_W]  = port_tag_in[i*TAG_W +: TAG_W];
                        lane_id_d[k*ID_W +: ID_W]     = ID_W'(i + 1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_data_out  <= '0;
            lane_tag_out   <= '0;
            lane_id_out    <= '0;
            lane_valid_out <= '0;
            ptr_q          <= '0;
        end else if (load) begin
            lane_data_out  <= lane_data_d;
            lane_tag_out   <= lane_tag_d;
            lane_id_out    <= lane_id_d;
            lane_valid_out <= lane_valid_d;
            if (any_grant) begin
                ptr_q <= (last_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : last_idx + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_request_compactor.sv
// Bench for request_compactor: directed scenarios plus random traffic against a queue-based
// round-robin model that tracks pending port requests and the current lane group.
module tb_request_compactor;

    localparam int NP  = 4;
    localparam int NL  = 2;
    localparam int W   = 8;
    localparam int TW  = 2;
    localparam int IDW = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NP*W-1:0]   port_data_in = '0;
    logic [NP*TW-1:0]  port_tag_in = '0;
    logic [NP-1:0]     port_valid_in = '0;
    logic [NP-1:0]     port_ready_out;
    logic [NL*W-1:0]   lane_data_out;
    logic [NL*TW-1:0]  lane_tag_out;
    logic [NL*IDW-1:0] lane_id_out;
    logic [NL-1:0]     lane_valid_out;
    logic              out_ready_in = 1'b0;

    request_compactor #(
        .WIDTH(W), .TAG_W(TW), .NUM_PORTS(NP), .NUM_LANES(NL), .ID_W(IDW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .port_data_in(port_data_in),
        .port_tag_in(port_tag_in),
        .port_valid_in(port_valid_in),
        .port_ready_out(port_ready_out),
        .lane_data_out(lane_data_out),
        .lane_tag_out(lane_tag_out),
        .lane_id_out(lane_id_out),
        .lane_valid_out(lane_valid_out),
        .out_ready_in(out_ready_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  d;
        logic [TW-1:0] t;
        int            id;
    } lane_t;

    // Model state: pending request per port, current lane group, round-robin pointer.
    bit            pv [NP];
    logic [W-1:0]  pd [NP];
    logic [TW-1:0] pt [NP];
    lane_t         mlanes[$];
    int            mptr;
    int            checks = 0;
    int            errors = 0;
    logic [NP-1:0] rdy;
    int            gcnt [NP];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            port_valid_in[i]         = pv[i];
            port_data_in[i*W +: W]   = pd[i];
            port_tag_in[i*TW +: TW]  = pt[i];
        end
    endtask

    task automatic check_lanes();
        logic [NL*W-1:0]   ed = '0;
        logic [NL*TW-1:0]  et = '0;
        logic [NL*IDW-1:0] ei = '0;
        logic [NL-1:0]     ev = '0;
        foreach (mlanes[k]) begin
            ed[k*W +: W]     = mlanes[k].d;
            et[k*TW +: TW]   = mlanes[k].t;
            ei[k*IDW +: IDW] = IDW'(mlanes[k].id);
            ev[k]            = 1'b1;
        end
        check("lane_valid", 64'(lane_valid_out), 64'(ev));
        check("lane_id", 64'(lane_id_out), 64'(ei));
        check("lane_data", 64'(lane_data_out), 64'(ed));
        check("lane_tag", 64'(lane_tag_out), 64'(et));
    endtask

    // One clock cycle: present pending requests, check ready, advance model, check lanes.
    task automatic step(input bit ordy, output logic [NP-1:0] seen);
        int            gq[$];
        logic [NP-1:0] er;
        bit            load;
        @(negedge clk);
        out_ready_in = ordy;
        drive();
        #1;
        load = (mlanes.size() == 0) || ordy;
        er = '0;
        if (load) begin
            for (int j = 0; j < NP; j++) begin
                int p = (mptr + j) % NP;
                if (pv[p] && gq.size() < NL) gq.push_back(p);
            end
        end
        foreach (gq[n]) er[gq[n]] = 1'b1;
        check("ready", 64'(port_ready_out), 64'(er));
        seen = port_ready_out;
        @(posedge clk);
        if (load) begin
            mlanes = {};
            foreach (gq[n]) begin
                lane_t l;
                l.d = pd[gq[n]];
                l.t = pt[gq[n]];
                l.id = gq[n] + 1;
                mlanes.push_back(l);
                pv[gq[n]] = 1'b0;
            end
            if (gq.size() > 0) mptr = (gq[gq.size()-1] + 1) % NP;
        end
        #1;
        check_lanes();
    endtask

    task automatic load_all(input logic [W-1:0] base);
        for (int i = 0; i < NP; i++) begin
            pv[i] = 1'b1;
            pd[i] = base + W'(i);
            pt[i] = TW'(i);
        end
    endtask

    initial begin
        for (int i = 0; i < NP; i++) begin
            pv[i] = 1'b0; pd[i] = '0; pt[i] = '0; gcnt[i] = 0;
        end
        mptr = 0;
        #12;
        check("rst_ready", 64'(port_ready_out), 64'(0));
        check_lanes();
        @(negedge clk);
        rst_n = 1'b1;

        // All four valid from ptr=0: ports 0,1 then 2,3.
        load_all(8'hA0);
        step(1'b1, rdy);
        check("tp_rdy0", 64'(rdy), 64'(4'b0011));
        check("tp_lanes0", 64'(lane_data_out), 64'(16'hA1A0));
        step(1'b1, rdy);
        check("tp_rdy1", 64'(rdy), 64'(4'b1100));
        check("tp_ids1", 64'(lane_id_out), 64'({3'd4, 3'd3}));

        // Sparse: only port 2, leaves ptr=3.
        pv[2] = 1'b1; pd[2] = 8'h5C; pt[2] = 2'd2;
        step(1'b1, rdy);
        check("sparse_valid", 64'(lane_valid_out), 64'(2'b01));
        check("sparse_id", 64'(lane_id_out), 64'({3'd0, 3'd3}));

        // Wrap: ports 3 and 0 from ptr=3.
        pv[0] = 1'b1; pd[0] = 8'h10; pt[0] = 2'd1;
        pv[3] = 1'b1; pd[3] = 8'h13; pt[3] = 2'd3;
        step(1'b1, rdy);
        check("wrap_rdy", 64'(rdy), 64'(4'b1001));
        check("wrap_ids", 64'(lane_id_out), 64'({3'd1, 3'd4}));

        // Stall with all ports valid, then release.
        load_all(8'h30);
        step(1'b1, rdy);
        load_all(8'h40);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, rdy);
            check("stall_rdy", 64'(rdy), 64'(0));
        end
        step(1'b1, rdy);

        // Fairness: everyone valid for 8 cycles.
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NP; i++) begin
                if (!pv[i]) begin
                    pv[i] = 1'b1; pd[i] = W'($urandom); pt[i] = TW'($urandom);
                end
            end
            step(1'b1, rdy);
            for (int i = 0; i < NP; i++) gcnt[i] += int'(rdy[i]);
        end
        for (int i = 0; i < NP; i++) check("fair_cnt", 64'(gcnt[i]), 64'(4));

        // Random traffic with random backpressure.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NP; i++) begin
                if (!pv[i] && ($urandom_range(1, 0) == 1)) begin
                    pv[i] = 1'b1; pd[i] = W'($urandom); pt[i] = TW'($urandom);
                end
            end
            step($urandom_range(9, 0) < 7, rdy);
        end

        // Reset mid-stall: lanes drop before the next edge, ptr back to 0.
        load_all(8'h60);
        step(1'b1, rdy);
        step(1'b0, rdy);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(lane_valid_out), 64'(0));
        check("rst_mid_id", 64'(lane_id_out), 64'(0));
        check("rst_mid_ready", 64'(port_ready_out), 64'(0));
        mlanes = {};
        mptr = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        load_all(8'h70);
        step(1'b1, rdy);
        check("post_rst_rdy", 64'(rdy), 64'(4'b0011));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
